// File: rtl/reg_bank.sv
// Register bank with per-word busy (scoreboard) bits and two registered read ports.
// Define REG_BANK_BYPASS_EN to forward same-edge writes/reserves to the read outputs.
module reg_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] Write_Register,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] Reserve_Register,
  input  logic [ADDR_W-1:0] Read_Register1,
  input  logic [ADDR_W-1:0] Read_Register2,
  output logic [DATA_W-1:0] Read_Data1,
  output logic [DATA_W-1:0] Read_Data2,
  output logic              Read_Valid1,
  output logic              Read_Valid2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_en;
  logic              rsv_en;
  logic [DATA_W-1:0] rd_data1_p0;
  logic [DATA_W-1:0] rd_data2_p0;
  logic              vld1_p0;
  logic              vld2_p0;

  // Register 0 is hardwired: never written, never reserved.
  assign wr_en  = RegWrite && (Write_Register != '0);
  assign rsv_en = Reserve && (Reserve_Register != '0);

  // Reserve is applied after the write so it wins on an address collision.
  always_comb begin
    busy_nxt = busy;
    if (wr_en)
      busy_nxt[Write_Register] = 1'b0;
    if (rsv_en)
      busy_nxt[Reserve_Register] = 1'b1;
  end

`ifdef REG_BANK_BYPASS_EN
  function automatic logic [DATA_W-1:0] fwd_data(input logic [ADDR_W-1:0] addr,
                                                 input logic [DATA_W-1:0] stored);
    return (wr_en && (Write_Register == addr)) ? Write_Data : stored;
  endfunction

  assign rd_data1_p0 = fwd_data(Read_Register1, mem[Read_Register1]);
  assign rd_data2_p0 = fwd_data(Read_Register2, mem[Read_Register2]);
  assign vld1_p0     = ~busy_nxt[Read_Register1];
  assign vld2_p0     = ~busy_nxt[Read_Register2];
`else
  assign rd_data1_p0 = mem[Read_Register1];
  assign rd_data2_p0 = mem[Read_Register2];
  assign vld1_p0     = ~busy[Read_Register1];
  assign vld2_p0     = ~busy[Read_Register2];
`endif

  // Stage p0 -> registered read outputs and storage update.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      busy        <= '0;
      Read_Data1  <= '0;
      Read_Data2  <= '0;
      Read_Valid1 <= 1'b0;
      Read_Valid2 <= 1'b0;
    end else begin
      if (wr_en)
        mem[Write_Register] <= Write_Data;
      busy        <= busy_nxt;
      Read_Data1  <= rd_data1_p0;
      Read_Data2  <= rd_data2_p0;
      Read_Valid1 <= vld1_p0;
      Read_Valid2 <= vld2_p0;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed testbench for reg_bank; expectations follow REG_BANK_BYPASS_EN when defined.
module tb_reg_bank;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              RegWrite = 1'b0;
  logic [ADDR_W-1:0] Write_Register = '0;
  logic [DATA_W-1:0] Write_Data = '0;
  logic              Reserve = 1'b0;
  logic [ADDR_W-1:0] Reserve_Register = '0;
  logic [ADDR_W-1:0] Read_Register1 = '0;
  logic [ADDR_W-1:0] Read_Register2 = '0;
  logic [DATA_W-1:0] Read_Data1;
  logic [DATA_W-1:0] Read_Data2;
  logic              Read_Valid1;
  logic              Read_Valid2;

  int tests_run = 0;
  int tests_failed = 0;

  reg_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .RegWrite(RegWrite),
    .Write_Register(Write_Register),
    .Write_Data(Write_Data),
    .Reserve(Reserve),
    .Reserve_Register(Reserve_Register),
    .Read_Register1(Read_Register1),
    .Read_Register2(Read_Register2),
    .Read_Data1(Read_Data1),
    .Read_Data2(Read_Data2),
    .Read_Valid1(Read_Valid1),
    .Read_Valid2(Read_Valid2)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need finish");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    #1 Reset = 1'b1;
    #1;
    tests_run++;
    if ({Read_Data1, Read_Data2} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h %h, need 0 0", Read_Data1, Read_Data2);
    end
    tests_run++;
    if ({Read_Valid1, Read_Valid2} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b%b, need 00", Read_Valid1, Read_Valid2);
    end
    step();
    #2 Reset = 1'b0;
    Read_Register1 = 5'd4;
    Read_Register2 = 5'd31;
    step();
    tests_run++;
    if ({Read_Data1, Read_Valid1, Read_Data2, Read_Valid2} !== {32'h0, 1'b1, 32'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL post_reset_read: got %h/%b %h/%b, need 0/1 0/1",
               Read_Data1, Read_Valid1, Read_Data2, Read_Valid2);
    end
  endtask

  task automatic test_write_read();
    RegWrite = 1'b1; Write_Register = 5'd7; Write_Data = 32'hDEADBEEF;
    Read_Register1 = 5'd0; Read_Register2 = 5'd0;
    step();
    RegWrite = 1'b0;
    Read_Register1 = 5'd7; Read_Register2 = 5'd7;
    step();
    tests_run++;
    if ({Read_Data1, Read_Valid1} !== {32'hDEADBEEF, 1'b1}) begin
      tests_failed++;
      $display("FAIL r7_port1: got %h/%b, need deadbeef/1", Read_Data1, Read_Valid1);
    end
    tests_run++;
    if ({Read_Data2, Read_Valid2} !== {32'hDEADBEEF, 1'b1}) begin
      tests_failed++;
      $display("FAIL r7_port2: got %h/%b, need deadbeef/1", Read_Data2, Read_Valid2);
    end
  endtask

  task automatic test_r0();
    RegWrite = 1'b1; Write_Register = 5'd0; Write_Data = 32'h12345678;
    Read_Register1 = 5'd0; Read_Register2 = 5'd0;
    step();
    RegWrite = 1'b0;
    step();
    tests_run++;
    if ({Read_Data1, Read_Valid1} !== {32'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL r0_write_ignored: got %h/%b, need 0/1", Read_Data1, Read_Valid1);
    end
    Reserve = 1'b1; Reserve_Register = 5'd0;
    step();
    Reserve = 1'b0;
    tests_run++;
    if ({Read_Data2, Read_Valid2} !== {32'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL r0_reserve_same_edge: got %h/%b, need 0/1", Read_Data2, Read_Valid2);
    end
    step();
    tests_run++;
    if ({Read_Valid1, Read_Valid2} !== 2'b11) begin
      tests_failed++;
      $display("FAIL r0_never_busy: got %b%b, need 11", Read_Valid1, Read_Valid2);
    end
  endtask

  task automatic test_reserve();
    Reserve = 1'b1; Reserve_Register = 5'd3;
    Read_Register1 = 5'd0; Read_Register2 = 5'd0;
    step();
    Reserve = 1'b0;
    Read_Register1 = 5'd3;
    step();
    tests_run++;
    if ({Read_Data1, Read_Valid1} !== {32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL r3_reserved: got %h/%b, need 0/0", Read_Data1, Read_Valid1);
    end
    RegWrite = 1'b1; Write_Register = 5'd3; Write_Data = 32'h55;
    Read_Register1 = 5'd0;
    step();
    RegWrite = 1'b0;
    Read_Register1 = 5'd3;
    step();
    tests_run++;
    if ({Read_Data1, Read_Valid1} !== {32'h55, 1'b1}) begin
      tests_failed++;
      $display("FAIL r3_written: got %h/%b, need 55/1", Read_Data1, Read_Valid1);
    end
    // Collision edge: r3 read on port 1 during the edge itself.
    RegWrite = 1'b1; Write_Register = 5'd3; Write_Data = 32'h66;
    Reserve = 1'b1; Reserve_Register = 5'd3;
    step();
    RegWrite = 1'b0; Reserve = 1'b0;
    tests_run++;
`ifdef REG_BANK_BYPASS_EN
    if ({Read_Data1, Read_Valid1} !== {32'h66, 1'b0}) begin
      tests_failed++;
      $display("FAIL r3_collision_same_edge: got %h/%b, need 66/0", Read_Data1, Read_Valid1);
    end
`else
    if ({Read_Data1, Read_Valid1} !== {32'h55, 1'b1}) begin
      tests_failed++;
      $display("FAIL r3_collision_same_edge: got %h/%b, need 55/1", Read_Data1, Read_Valid1);
    end
`endif
    step();
    tests_run++;
    if ({Read_Data1, Read_Valid1} !== {32'h66, 1'b0}) begin
      tests_failed++;
      $display("FAIL r3_collision_after: got %h/%b, need 66/0", Read_Data1, Read_Valid1);
    end
  endtask

  task automatic test_bypass();
    RegWrite = 1'b1; Write_Register = 5'd9; Write_Data = 32'hA5A5A5A5;
    Read_Register1 = 5'd9; Read_Register2 = 5'd9;
    step();
    RegWrite = 1'b0;
    tests_run++;
`ifdef REG_BANK_BYPASS_EN
    if ({Read_Data1, Read_Valid1, Read_Data2} !== {32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5}) begin
      tests_failed++;
      $display("FAIL r9_same_edge: got %h/%b %h, need a5a5a5a5/1 a5a5a5a5",
               Read_Data1, Read_Valid1, Read_Data2);
    end
`else
    if ({Read_Data1, Read_Valid1, Read_Data2} !== {32'h0, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL r9_same_edge: got %h/%b %h, need 0/1 0", Read_Data1, Read_Valid1, Read_Data2);
    end
`endif
    step();
    tests_run++;
    if ({Read_Data1, Read_Valid1} !== {32'hA5A5A5A5, 1'b1}) begin
      tests_failed++;
      $display("FAIL r9_next_read: got %h/%b, need a5a5a5a5/1", Read_Data1, Read_Valid1);
    end
  endtask

  task automatic test_dual_port();
    RegWrite = 1'b1; Write_Register = 5'd1; Write_Data = 32'h11111111;
    step();
    Write_Register = 5'd2; Write_Data = 32'h22222222;
    step();
    RegWrite = 1'b0;
    Read_Register1 = 5'd1; Read_Register2 = 5'd2;
    step();
    tests_run++;
    if ({Read_Data1, Read_Data2} !== {32'h11111111, 32'h22222222}) begin
      tests_failed++;
      $display("FAIL dual_port_a: got %h %h, need 11111111 22222222", Read_Data1, Read_Data2);
    end
    Read_Register1 = 5'd2; Read_Register2 = 5'd7;
    step();
    tests_run++;
    if ({Read_Data1, Read_Data2} !== {32'h22222222, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("FAIL dual_port_b: got %h %h, need 22222222 deadbeef", Read_Data1, Read_Data2);
    end
  endtask

  task automatic test_reset_mid();
    Reserve = 1'b1; Reserve_Register = 5'd5;
    step();
    Reserve = 1'b0;
    Read_Register1 = 5'd5; Read_Register2 = 5'd7;
    step();
    tests_run++;
    if ({Read_Valid1, Read_Data2, Read_Valid2} !== {1'b0, 32'hDEADBEEF, 1'b1}) begin
      tests_failed++;
      $display("FAIL pre_reset_state: got %b %h/%b, need 0 deadbeef/1",
               Read_Valid1, Read_Data2, Read_Valid2);
    end
    #3 Reset = 1'b1;
    #1;
    tests_run++;
    if ({Read_Data1, Read_Valid1, Read_Data2, Read_Valid2} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset_clear: got %h/%b %h/%b, need 0/0 0/0",
               Read_Data1, Read_Valid1, Read_Data2, Read_Valid2);
    end
    // Write and reserve presented while reset is held must be dropped.
    RegWrite = 1'b1; Write_Register = 5'd6; Write_Data = 32'hFFFF0000;
    Reserve = 1'b1; Reserve_Register = 5'd8;
    step();
    RegWrite = 1'b0; Reserve = 1'b0;
    #2 Reset = 1'b0;
    Read_Register1 = 5'd5; Read_Register2 = 5'd7;
    RegWrite = 1'b1; Write_Register = 5'd10; Write_Data = 32'hCAFEF00D;
    step();
    RegWrite = 1'b0;
    tests_run++;
    if ({Read_Data1, Read_Valid1, Read_Data2, Read_Valid2} !== {32'h0, 1'b1, 32'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL post_reset_r5_r7: got %h/%b %h/%b, need 0/1 0/1",
               Read_Data1, Read_Valid1, Read_Data2, Read_Valid2);
    end
    Read_Register1 = 5'd6; Read_Register2 = 5'd8;
    step();
    tests_run++;
    if ({Read_Data1, Read_Valid1, Read_Valid2} !== {32'h0, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_ignores_ops: got %h/%b %b, need 0/1 1",
               Read_Data1, Read_Valid1, Read_Valid2);
    end
    Read_Register1 = 5'd10;
    step();
    tests_run++;
    if ({Read_Data1, Read_Valid1} !== {32'hCAFEF00D, 1'b1}) begin
      tests_failed++;
      $display("FAIL first_edge_after_reset: got %h/%b, need cafef00d/1", Read_Data1, Read_Valid1);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_r0();
    test_reserve();
    test_bypass();
    test_dual_port();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
